// File: rtl/commit_arbiter_pkg.sv
// Commit-bus definitions shared by the arbiter and its priority picker.
// The packet width macros are normally supplied by aDefinitions.v; the guarded fallbacks keep this slice self-contained.
`ifndef COMMIT_PACKET_SIZE
`define COMMIT_PACKET_SIZE 8
`endif
`ifndef COMMIT_RSID_RNG
`define COMMIT_RSID_RNG 3:0
`endif

package commit_arbiter_pkg;
   localparam int COMMIT_PKT_W = `COMMIT_PACKET_SIZE;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   typedef logic [3:0] stn_idx_t;
endpackage

// File: rtl/rr_priority_pick.sv
// Round-robin pick: the search starts one past the pointer and wraps.
// The first requester found wins.
module rr_priority_pick
   import commit_arbiter_pkg::*;
#(
   parameter int N = 4
)
(
   input  logic [N-1:0] requests,
   input  stn_idx_t     pointer,
   output logic [N-1:0] winner,
   output stn_idx_t     index,
   output logic         any
);
   int k;

   always_comb begin
      winner = '0;
      index  = '0;
      any    = 1'b0;
      k      = 0;
      for (int i = 1; i <= N; i++) begin
         k = int'(pointer) + i;
         if (k >= N) k = k - N;
         if (!any && k < N && requests[k]) begin
            any       = 1'b1;
            winner[k] = 1'b1;
            index     = stn_idx_t'(k);
         end
      end
   end
endmodule

// File: rtl/commit_arbiter.sv
// Round-robin commit-bus arbiter. It issues a one-cycle grant pulse and
// drives the granted station's packet onto the bus in the next cycle.
module commit_arbiter
   import commit_arbiter_pkg::*;
#(
   parameter int NUM_STATIONS = 4,
   parameter int PKT_W        = COMMIT_PKT_W
)
(
   input  logic                          Clock,
   input  logic                          Reset,
   input  logic [NUM_STATIONS-1:0]       iCommitRequest,
   input  logic [NUM_STATIONS*PKT_W-1:0] iCommitData,
   output logic [NUM_STATIONS-1:0]       oCommitGranted,
   output logic [PKT_W-1:0]              oCommitBus,
   output logic                          oCommitValid,
   output logic [3:0]                    oCommitSource
);
   logic [0:0]              state;
   logic                    armed;
   stn_idx_t                last_granted;
   logic [NUM_STATIONS-1:0] eligible;
   logic [NUM_STATIONS-1:0] pick_hot;
   stn_idx_t                pick_idx;
   logic                    pick_any;

   // The station granted this cycle is masked because its request drop arrives one cycle late.
   // The armed flop holds off the first grant until the second edge after reset releases.
   assign eligible = armed ? (iCommitRequest & ~oCommitGranted) : '0;

   rr_priority_pick #(.N(NUM_STATIONS)) u_pick (
      .requests (eligible),
      .pointer  (last_granted),
      .winner   (pick_hot),
      .index    (pick_idx),
      .any      (pick_any)
   );

   always_ff @(posedge Clock) begin
      if (!Reset) begin
         state          <= ST_IDLE;
         armed          <= 1'b0;
         last_granted   <= stn_idx_t'(NUM_STATIONS - 1);
         oCommitGranted <= '0;
         oCommitBus     <= '0;
         oCommitValid   <= 1'b0;
         oCommitSource  <= '0;
      end else begin
         armed          <= 1'b1;
         oCommitGranted <= pick_hot;
         state          <= pick_any ? ST_GRANT : ST_IDLE;
         if (pick_any) last_granted <= pick_idx;
         // In the GRANT state, last_granted holds the station that is granted in this cycle.
         oCommitValid <= (state == ST_GRANT);
         if (state == ST_GRANT) begin
            oCommitBus    <= iCommitData[int'(last_granted)*PKT_W +: PKT_W];
            oCommitSource <= last_granted;
         end
      end
   end
endmodule

// File: tb/tb_commit_arbiter.sv
// Directed bench for commit_arbiter: reset, rotation, single requester, fairness,
// the request-drop mask and reset while a grant is in flight.
module tb_commit_arbiter;
   localparam int N = 4;
   localparam int W = 8;

   logic         Clock = 1'b0;
   logic         Reset;
   logic [N-1:0] req;
   logic [N*W-1:0] data;
   logic [N-1:0] gnt;
   logic [W-1:0] bus;
   logic         vld;
   logic [3:0]   src;

   int n_chk = 0;
   int n_err = 0;

   always #5 Clock = ~Clock;

   commit_arbiter #(.NUM_STATIONS(N), .PKT_W(W)) dut (
      .Clock          (Clock),
      .Reset          (Reset),
      .iCommitRequest (req),
      .iCommitData    (data),
      .oCommitGranted (gnt),
      .oCommitBus     (bus),
      .oCommitValid   (vld),
      .oCommitSource  (src)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic idle(input int n);
      req = '0;
      repeat (n) tick();
   endtask

   initial begin
      int c1, c3, adj, ng;
      logic [N-1:0] prev;

      Reset = 1'b0;
      req   = '1;
      data  = {8'h13, 8'h12, 8'h11, 8'h10};
      repeat (3) begin
         tick();
         chk("rst_gnt", 32'(gnt), 32'h0);
         chk("rst_vld", 32'(vld), 32'h0);
         chk("rst_bus", 32'(bus), 32'h0);
         chk("rst_src", 32'(src), 32'h0);
      end

      // All four stations request continuously.
      Reset = 1'b1;
      tick();
      chk("arm_gnt", 32'(gnt), 32'h0);
      for (int n = 0; n < 8; n++) begin
         tick();
         chk("rr_gnt", 32'(gnt), 32'(1) << (n % 4));
         chk("rr_vld", 32'(vld), (n > 0) ? 32'h1 : 32'h0);
         if (n > 0) begin
            chk("rr_src", 32'(src), 32'((n - 1) % 4));
            chk("rr_bus", 32'(bus), 32'h10 + 32'((n - 1) % 4));
         end
      end
      req = '0;
      tick();
      chk("tail_gnt", 32'(gnt), 32'h0);
      chk("tail_vld", 32'(vld), 32'h1);
      chk("tail_src", 32'(src), 32'h3);
      tick();
      chk("hold_vld", 32'(vld), 32'h0);
      chk("hold_bus", 32'(bus), 32'h13);
      idle(2);

      // Single requester: station 2.
      data[2*W +: W] = 8'h2A;
      req = 4'b0100;
      tick();
      chk("one_gnt", 32'(gnt), 32'h4);
      tick();
      chk("one_mask", 32'(gnt), 32'h0);
      chk("one_vld", 32'(vld), 32'h1);
      chk("one_bus", 32'(bus), 32'h2A);
      chk("one_src", 32'(src), 32'h2);
      req = '0;
      tick();
      chk("one_drop_gnt", 32'(gnt), 32'h0);
      chk("one_drop_vld", 32'(vld), 32'h0);
      chk("one_drop_bus", 32'(bus), 32'h2A);
      idle(2);

      // Stations 1 and 3 request together for 20 cycles.
      req = 4'b1010;
      c1 = 0; c3 = 0; adj = 0; prev = '0;
      repeat (20) begin
         tick();
         if (gnt == 4'b0010) c1++;
         if (gnt == 4'b1000) c3++;
         if (gnt == prev) adj++;
         prev = gnt;
      end
      chk("fair_c1", 32'(c1), 32'd10);
      chk("fair_c3", 32'(c3), 32'd10);
      chk("fair_alt", 32'(adj), 32'd0);
      idle(3);

      // A single station holds its request for 10 cycles.
      req = 4'b0001;
      ng = 0; adj = 0; prev = '0;
      repeat (10) begin
         tick();
         if (gnt != '0) begin
            ng++;
            if (prev != '0) adj++;
         end
         prev = gnt;
      end
      chk("solo_cnt", 32'(ng), 32'd5);
      chk("solo_adj", 32'(adj), 32'd0);
      idle(3);

      // Reset is asserted during station 1's grant cycle.
      data[1*W +: W] = 8'h77;
      req = 4'b0010;
      tick();
      chk("mid_gnt", 32'(gnt), 32'h2);
      Reset = 1'b0;
      tick();
      chk("mid_rst_vld", 32'(vld), 32'h0);
      chk("mid_rst_gnt", 32'(gnt), 32'h0);
      chk("mid_rst_bus", 32'(bus), 32'h0);
      Reset = 1'b1;
      req = 4'b0011;
      tick();
      chk("mid_arm_gnt", 32'(gnt), 32'h0);
      chk("mid_arm_vld", 32'(vld), 32'h0);
      tick();
      chk("mid_first_gnt", 32'(gnt), 32'h1);
      chk("mid_first_vld", 32'(vld), 32'h0);
      tick();
      chk("mid_next_gnt", 32'(gnt), 32'h2);
      chk("mid_next_vld", 32'(vld), 32'h1);
      chk("mid_next_bus", 32'(bus), 32'h10);
      chk("mid_next_src", 32'(src), 32'h0);
      idle(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/commit_arbiter.md
COMMIT_ARBITER -- requirements
Module: commit_arbiter

Interface
- REQ-001 SHALL have parameter NUM_STATIONS, default 4: number of reservation stations sharing the commit bus (2..16).
- REQ-002 SHALL have parameter PKT_W, default `COMMIT_PACKET_SIZE: width of one station commit packet.
- REQ-003 SHALL have port Clock, input, 1: single clock; all logic on rising edge.
- REQ-004 SHALL have port Reset, input, 1: synchronous reset, active-low.
- REQ-005 SHALL have port iCommitRequest, input, NUM_STATIONS: per-station commit request, level, held until granted.
- REQ-006 SHALL have port iCommitData, input, NUM_STATIONS*PKT_W: station packets concatenated, station k at bits [k*PKT_W +: PKT_W].
- REQ-007 SHALL have port oCommitGranted, output, NUM_STATIONS: one-hot (or zero) grant pulse.
- REQ-008 SHALL have port oCommitBus, output, PKT_W: registered winning packet.
- REQ-009 SHALL have port oCommitValid, output, 1: oCommitBus carries a packet this cycle.
- REQ-010 SHALL have port oCommitSource, output, 4: station index of the packet on oCommitBus.

Function
- REQ-011 SHALL register oCommitGranted; at most one bit is set in any cycle.
- REQ-012 SHALL arbitrate round-robin: search starts at station (last_granted+1) mod NUM_STATIONS, wrapping; first eligible requester wins.
- REQ-013 SHALL treat a station as eligible when its iCommitRequest=1 and it is not the station whose grant bit is high in the current cycle (request-drop latency mask).
- REQ-014 SHALL, with a request at edge t, assert the grant for one cycle t+1 at the earliest; the station holds its packet stable during that grant cycle.
- REQ-015 SHALL capture iCommitData of the granted station at the end of the grant cycle and present it on oCommitBus with oCommitValid=1 and oCommitSource=index in the following cycle (request-to-bus latency 2).
- REQ-016 SHALL sustain one commit per cycle when two or more stations request continuously (back-to-back grants to different stations).
- REQ-017 SHALL, with a single continuously requesting station, grant it every other cycle (mask of REQ-013).
- REQ-018 SHALL hold oCommitBus at its last value while oCommitValid=0.
- REQ-019 SHALL update last_granted only when a grant is issued; with no requests, the pointer holds.
- REQ-020 SHALL ignore requests from index >= NUM_STATIONS (none exist by construction).
- REQ-021 SHALL use a two-state FSM: IDLE (no grant outstanding) and GRANT (grant bit high this cycle); IDLE->GRANT on any eligible request; GRANT->GRANT on another eligible request; GRANT->IDLE otherwise.

Reset
- REQ-022 SHALL, while Reset=0 at a rising edge, clear oCommitGranted, oCommitValid, oCommitBus, oCommitSource to 0, set FSM to IDLE and last_granted to NUM_STATIONS-1 (station 0 has first priority).
- REQ-023 SHALL, on reset asserted mid-grant, discard the in-flight packet: oCommitValid is 0 in the cycle after reset.
- REQ-024 SHALL issue the first grant no earlier than the second edge after Reset returns to 1.

Structure
- REQ-025 SHALL take packet widths and field ranges (`COMMIT_PACKET_SIZE, `COMMIT_RSID_RNG) from aDefinitions.v; no local redefinition.
- REQ-026 SHALL place the round-robin priority search in one sub-module, rr_priority_pick (requests, pointer -> one-hot winner, index, any).

Verification
- REQ-027 Reset: Reset=0 with all requests=1 for 3 cycles -> grants, valid, bus all 0; after release first grant to station 0.
- REQ-028 Single requester: station 2 requests with packet 0x2A from cycle 5 -> grant[2] at cycle 6, bus=0x2A, valid=1, source=2 at cycle 7; station drops request at cycle 7 -> no further grants.
- REQ-029 All four request continuously -> grants 0,1,2,3,0,... on consecutive cycles; valid=1 every cycle from third cycle; no station granted twice in a row.
- REQ-030 Fairness: stations 1 and 3 request continuously for 20 cycles -> exactly 10 grants each, alternating.
- REQ-031 Single station held requesting 10 cycles -> grant pulses on every other cycle (5 grants), never on adjacent cycles.
- REQ-032 Reset asserted in the grant cycle for station 1 -> packet never appears, oCommitValid=0, pointer restarts at station 0.
